// File: rtl/dw03_timer_arbiter_pkg.sv
// Shared types and defaults for the dw03 timer arbiter.
// Holds the FSM state encoding and the default WIDTH / NREQ values.
package dw03_tmr_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } tmr_state_t;

endpackage

// File: rtl/dw03_timer_arbiter_if.sv
// Requester-side bus of the dw03 timer arbiter.
// The master modport belongs to the requesters and the slave modport to the arbiter.
interface dw03_timer_arbiter_if
    import dw03_tmr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] cnt_val;
    logic [NREQ-1:0]       dir;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       done;
    logic                  busy;
    logic [WIDTH-1:0]      count;

    modport master (
        output req, cnt_val, dir,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, cnt_val, dir,
        output gnt, done, busy, count
    );

endinterface

// File: rtl/dw03_bictr_core.sv
// Loadable up/down counter shared by all requesters of the timer arbiter.
// It stops stepping once it reaches count_to; tercnt flags that condition.
module dw03_bictr_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             up_dn,
    input  logic             cen,
    input  logic [WIDTH-1:0] count_to,
    output logic [WIDTH-1:0] count,
    output logic             tercnt
);

    assign tercnt = (count == count_to);

    // Counter register: reset, load, or step toward count_to (modulo 2^WIDTH).
    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= data;
        end else if (cen && !tercnt) begin
            count <= up_dn ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/dw03_timer_arbiter.sv
// Round-robin arbiter granting one shared timed-interval counter to NREQ requesters.
// Optional macro DW03_TMR_HOLD_EN adds a 'hold' input that freezes the interval in RUN.
module dw03_timer_arbiter
    import dw03_tmr_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic clk,
    input  logic reset,
`ifdef DW03_TMR_HOLD_EN
    input  logic hold,
`endif
    dw03_timer_arbiter_if.slave bus
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    tmr_state_t       state;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    last_owner;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    idx;
    logic             found;
    logic [WIDTH-1:0] own_v;
    logic             own_dir;
    logic [NREQ-1:0]  gnt_q;
    logic [NREQ-1:0]  done_q;
    logic             hold_run;
    logic             abort;
    logic             ctr_load;
    logic             ctr_cen;
    logic [WIDTH-1:0] ctr_data;
    logic [WIDTH-1:0] ctr_to;
    logic [WIDTH-1:0] count;
    logic             tercnt;
    logic [WIDTH-1:0] v_arr [NREQ];

`ifdef DW03_TMR_HOLD_EN
    assign hold_run = hold;
`else
    assign hold_run = 1'b0;
`endif

    for (genvar i = 0; i < NREQ; i++) begin : g_vsplit
        assign v_arr[i] = bus.cnt_val[i*WIDTH +: WIDTH];
    end

    // The owner releasing its request while the interval is set up or running cancels it.
    assign abort = ((state == LOAD) || (state == RUN)) && !bus.req[owner];

    // Round-robin search starting one past the previous owner.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        winner = last_owner;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last_owner) + k) % NREQ);
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // Counter control comes from the latched interval, never from live inputs.
    assign ctr_load = (state == LOAD) && !abort;
    assign ctr_cen  = (state == RUN) && !abort && !hold_run;
    assign ctr_data = own_dir ? '0 : own_v;
    assign ctr_to   = own_dir ? own_v : '0;

    dw03_bictr_core #(
        .WIDTH (WIDTH)
    ) u_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .data     (ctr_data),
        .up_dn    (own_dir),
        .cen      (ctr_cen),
        .count_to (ctr_to),
        .count    (count),
        .tercnt   (tercnt)
    );

    // Control FSM with registered grant and done outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= IW'(NREQ - 1);
            own_v      <= '0;
            own_dir    <= 1'b0;
            gnt_q      <= '0;
            done_q     <= '0;
        end else begin
            done_q <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        state   <= LOAD;
                        owner   <= winner;
                        own_v   <= v_arr[winner];
                        own_dir <= bus.dir[winner];
                        gnt_q   <= NREQ'(1) << winner;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state      <= IDLE;
                        gnt_q      <= '0;
                        last_owner <= owner;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state      <= IDLE;
                        gnt_q      <= '0;
                        last_owner <= owner;
                    end else if (!hold_run && tercnt) begin
                        state  <= DONE;
                        done_q <= gnt_q;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    gnt_q      <= '0;
                    last_owner <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.busy  = (state != IDLE);
    assign bus.count = count;

endmodule

// File: tb/tb_dw03_timer_arbiter.sv
// Directed bench for dw03_timer_arbiter (WIDTH=8, NREQ=4).
// Define DW03_TMR_HOLD_EN for both RTL and bench to include the hold scenario.
module tb_dw03_timer_arbiter;

    logic clk = 1'b0;
    logic reset;
`ifdef DW03_TMR_HOLD_EN
    logic hold;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dw03_timer_arbiter_if #(.WIDTH(8), .NREQ(4)) bus ();

    dw03_timer_arbiter #(
        .WIDTH (8),
        .NREQ  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef DW03_TMR_HOLD_EN
        .hold  (hold),
`endif
        .bus   (bus)
    );

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.req     = '0;
        bus.cnt_val = '0;
        bus.dir     = '0;
`ifdef DW03_TMR_HOLD_EN
        hold        = 1'b0;
`endif
        tick();
        tick();
        check("rst_gnt",   32'(bus.gnt),   32'h0);
        check("rst_done",  32'(bus.done),  32'h0);
        check("rst_busy",  32'(bus.busy),  32'h0);
        check("rst_count", 32'(bus.count), 32'h0);
        reset = 1'b0;
        tick();

        // Up-count, V=3: gnt t+1, count 0..3 at t+2..t+5, done t+6, idle t+7.
        bus.cnt_val[7:0] = 8'd3;
        bus.dir          = 4'b0001;
        bus.req          = 4'b0001;
        tick();
        check("up_gnt",  32'(bus.gnt),  32'h1);
        check("up_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("up_count", 32'(bus.count), 32'(i));
            check("up_nodone", 32'(bus.done), 32'h0);
        end
        tick();
        check("up_done", 32'(bus.done), 32'h1);
        check("up_hold3", 32'(bus.count), 32'h3);
        bus.req = 4'b0000;
        tick();
        check("up_idle_busy", 32'(bus.busy), 32'h0);
        check("up_idle_done", 32'(bus.done), 32'h0);
        check("up_idle_gnt",  32'(bus.gnt),  32'h0);

        // Down-count, V=5: count 5..0 at t+2..t+7, done t+8.
        bus.cnt_val[7:0] = 8'd5;
        bus.dir          = 4'b0000;
        bus.req          = 4'b0001;
        tick();
        check("dn_gnt", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("dn_count", 32'(bus.count), 32'(5 - i));
        end
        tick();
        check("dn_done", 32'(bus.done), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("dn_idle_busy", 32'(bus.busy), 32'h0);

        // Reset so round-robin restarts at index 0.
        reset = 1'b1;
        tick();
        reset = 1'b0;

        // All four request with V=0: grants 0,1,2,3 every 4 cycles, single-cycle done.
        bus.cnt_val = '0;
        bus.dir     = 4'b1111;
        bus.req     = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("rr_gnt", 32'(bus.gnt), 32'(4'b0001 << n));
            tick();
            check("rr_count", 32'(bus.count), 32'h0);
            tick();
            check("rr_done", 32'(bus.done), 32'(4'b0001 << n));
            if (n == 3) bus.req = 4'b0000;
            tick();
            check("rr_done_pulse", 32'(bus.done), 32'h0);
            check("rr_idle_busy",  32'(bus.busy), 32'h0);
        end

        // Abort: req1 V=10 up dropped at count=4, req2 pending.
        bus.cnt_val[15:8]  = 8'd10;
        bus.cnt_val[23:16] = 8'd2;
        bus.dir            = 4'b0110;
        bus.req            = 4'b0110;
        tick();
        check("ab_gnt", 32'(bus.gnt), 32'h2);
        for (int i = 0; i < 5; i++) tick();
        check("ab_count4", 32'(bus.count), 32'h4);
        bus.req = 4'b0100;
        tick();
        check("ab_busy",  32'(bus.busy),  32'h0);
        check("ab_gnt0",  32'(bus.gnt),   32'h0);
        check("ab_done",  32'(bus.done),  32'h0);
        check("ab_count", 32'(bus.count), 32'h4);
        tick();
        check("ab_next_gnt", 32'(bus.gnt), 32'h4);
        // Abort in LOAD leaves the count untouched.
        bus.req = 4'b0000;
        tick();
        check("ab_load_busy",  32'(bus.busy),  32'h0);
        check("ab_load_count", 32'(bus.count), 32'h4);

        // Reset mid-RUN at count=7.
        bus.cnt_val[7:0] = 8'd9;
        bus.dir          = 4'b0001;
        bus.req          = 4'b0001;
        tick();
        check("mr_gnt", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        check("mr_count7", 32'(bus.count), 32'h7);
        reset   = 1'b1;
        bus.req = 4'b1001;
        tick();
        check("mr_count", 32'(bus.count), 32'h0);
        check("mr_gnt0",  32'(bus.gnt),   32'h0);
        check("mr_busy",  32'(bus.busy),  32'h0);
        reset = 1'b0;
        tick();
        check("mr_first_gnt", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("mr_abort_busy", 32'(bus.busy), 32'h0);

`ifdef DW03_TMR_HOLD_EN
        // Hold for 3 cycles at count=2, V=4 up: done moves from t+7 to t+10.
        bus.cnt_val[7:0] = 8'd4;
        bus.dir          = 4'b0001;
        bus.req          = 4'b0001;
        tick();
        check("hd_gnt", 32'(bus.gnt), 32'h1);
        tick();
        tick();
        tick();
        check("hd_count2", 32'(bus.count), 32'h2);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hd_frozen", 32'(bus.count), 32'h2);
            check("hd_gnt_hi", 32'(bus.gnt),   32'h1);
        end
        hold = 1'b0;
        tick();
        check("hd_count3", 32'(bus.count), 32'h3);
        tick();
        check("hd_count4", 32'(bus.count), 32'h4);
        check("hd_nodone", 32'(bus.done),  32'h0);
        tick();
        check("hd_done", 32'(bus.done), 32'h1);
        bus.req = 4'b0000;
        tick();
        check("hd_idle_busy", 32'(bus.busy), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dw03_timer_arbiter.md
DW03_TIMER_ARBITER -- requirements
Module: dw03_timer_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the counter and interval width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 req  input  NREQ  SHALL carry per-requester timed-interval requests, level, held until done.
REQ-006 cnt_val  input  NREQ*WIDTH  SHALL carry the per-requester interval V; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 dir  input  NREQ  SHALL select per-requester direction: 1 counts up 0->V; 0 counts down V->0.
REQ-008 gnt  output  NREQ  SHALL be one-hot (or zero) and mark the requester that owns the shared counter.
REQ-009 done  output  NREQ  SHALL carry a one-cycle completion pulse for the owning requester.
REQ-010 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-011 count  output  WIDTH  SHALL expose the shared counter value.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
- IDLE: if any req bit is set, select the winner -> LOAD; otherwise stay.
- LOAD -> RUN.
- RUN -> DONE at the terminal value; -> IDLE on abort.
- DONE -> IDLE.
REQ-013 Arbitration SHALL be round-robin:
- Search starts at index (last_owner+1) mod NREQ.
- last_owner resets to NREQ-1, so index 0 wins first.
REQ-014 On the IDLE->LOAD edge, the winner's index, V and dir SHALL be latched; later input changes SHALL NOT affect the active interval.
REQ-015 In LOAD, count SHALL be loaded with 0 (dir=1) or V (dir=0).
REQ-016 In RUN, count SHALL step by +1 (dir=1) or -1 (dir=0) each cycle, except when it equals the end value (V for up, 0 for down).
- At the end value, count SHALL hold and the next state SHALL be DONE.
REQ-017 Latency: req seen in IDLE at cycle t SHALL give gnt at t+1, count=start at t+2, and done at t+3+V.
REQ-018 V=0 SHALL produce exactly one RUN cycle, with done at t+3.
REQ-019 gnt SHALL be high in LOAD, RUN and DONE; done SHALL be high only in DONE.
REQ-020 Abort: if the owner's req drops in LOAD or RUN, the FSM SHALL go to IDLE next cycle.
- No done pulse; count holds its value.
- last_owner SHALL still be updated.
REQ-021 count arithmetic SHALL be modulo 2^WIDTH.
- The latched terminal check guarantees no wrap in normal operation.
REQ-022 last_owner SHALL update on DONE->IDLE and on abort.
REQ-023 Back-to-back service: a pending req SHALL be granted from the IDLE cycle immediately after DONE, with no extra gap.

Reset
REQ-024 With reset high at a clock edge, the block SHALL set:
- state=IDLE, count=0, gnt=0, done=0, busy=0, last_owner=NREQ-1.
REQ-025 Reset SHALL take priority over every other condition, including mid-RUN, and SHALL drop gnt on the following edge.

Configuration
REQ-026 Macro DW03_TMR_HOLD_EN SHALL add an input hold (1 bit).
- When hold is high in RUN, count and state SHALL freeze; gnt stays high.
- hold SHALL have no effect in other states.
- Abort and reset SHALL override hold.
REQ-027 Without DW03_TMR_HOLD_EN, the hold port SHALL be absent and RUN SHALL never stall.

Structure
REQ-028 Package dw03_tmr_pkg SHALL hold:
- the FSM state typedef (IDLE/LOAD/RUN/DONE);
- default WIDTH and NREQ constants.
REQ-029 Sub-module dw03_bictr_core SHALL implement the shared counter:
- ports: clk, reset, load, data, up_dn, cen, count_to, count, tercnt;
- sync active-high reset.
The FSM and arbiter SHALL stay in the top module.

Verification
REQ-030 Bench SHALL cover:
- req=0001, V0=3, dir0=1 -> gnt=0001 at t+1; count 0,1,2,3; done=0001 at t+6; busy low at t+7.
- req=0001, V0=5, dir0=0 -> count 5,4,3,2,1,0; done=0001 at t+8.
- req=1111, all V=0 -> grants 0,1,2,3 in order, each 4 cycles apart; every done is a single-cycle pulse.
- req1 with V=10, dir=1; req1 dropped at count=4 -> next cycle IDLE, no done, count holds 4; a pending req2 is granted next.
- reset pulsed mid-RUN at count=7 -> next edge count=0, gnt=0, state IDLE; first grant after reset goes to index 0.
- DW03_TMR_HOLD_EN defined: hold high 3 cycles at count=2 with V=4 up -> done delayed by exactly 3 cycles.
